// File: rtl/iter_mul_div_unit.sv
// Radix-2 iterative multiply/divide unit: shift-add multiply, restoring divide, on magnitudes
// with a final sign-fix cycle. Valid/ready on both sides, synchronous flush, async reset.
module iter_mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_x_q, neg_x_d;
    logic               y_zero_q, y_zero_d;
    logic [WIDTH-1:0]   x_orig_q, x_orig_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]   result_lo_q, result_lo_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic               div_zero_q, div_zero_d;

    logic               accept;
    logic               x_neg, y_neg;
    logic [WIDTH-1:0]   x_mag, y_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StDone:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready & ~flush;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        neg_res_d   = neg_res_q;
        neg_x_d     = neg_x_q;
        y_zero_d    = y_zero_q;
        x_orig_d    = x_orig_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        tag_d       = tag_q;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        out_tag_d   = out_tag_q;
        div_zero_d  = div_zero_q;

        x_neg   = ~in_op[0] & in_x[WIDTH-1];
        y_neg   = ~in_op[0] & in_y[WIDTH-1];
        x_mag   = x_neg ? -in_x : in_x;
        y_mag   = y_neg ? -in_y : in_y;
        // Multiply: add multiplicand into the top half when the multiplier LSB is set.
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        // Divide: acc holds {remainder, dividend bits still to shift in}.
        shifted = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = shifted[WIDTH-1:0] - opnd_q;
        quo     = acc_q[WIDTH-1:0];
        rem     = acc_q[2*WIDTH-1:WIDTH];
        prod    = neg_res_q ? -acc_q : acc_q;

        unique case (state_q)
            StIdle: ;
            StCalc: begin
                if (is_div_q) begin
                    if (shifted >= {1'b0, opnd_q}) begin
                        acc_d = {diff, acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else if (acc_q[0]) begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                out_tag_d  = tag_q;
                div_zero_d = 1'b0;
                if (!is_div_q) begin
                    {result_hi_d, result_lo_d} = prod;
                end else if (y_zero_q) begin
                    result_lo_d = '1;
                    result_hi_d = x_orig_q;
                    div_zero_d  = 1'b1;
                end else begin
                    result_lo_d = neg_res_q ? -quo : quo;
                    result_hi_d = neg_x_q ? -rem : rem;
                end
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Accept is only possible in idle or in a completing done, giving back-to-back issue.
        if (accept) begin
            is_div_d  = in_op[1];
            neg_res_d = x_neg ^ y_neg;
            neg_x_d   = x_neg;
            y_zero_d  = (in_y == '0);
            x_orig_d  = in_x;
            tag_d     = in_tag;
            cnt_d     = '0;
            opnd_d    = in_op[1] ? y_mag : x_mag;
            acc_d     = in_op[1] ? {{WIDTH{1'b0}}, x_mag} : {{WIDTH{1'b0}}, y_mag};
            state_d   = StCalc;
        end

        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            neg_res_q   <= 1'b0;
            neg_x_q     <= 1'b0;
            y_zero_q    <= 1'b0;
            x_orig_q    <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            tag_q       <= '0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            out_tag_q   <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            neg_res_q   <= neg_res_d;
            neg_x_q     <= neg_x_d;
            y_zero_q    <= y_zero_d;
            x_orig_q    <= x_orig_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            tag_q       <= tag_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
            out_tag_q   <= out_tag_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign result_lo = result_lo_q;
    assign result_hi = result_hi_q;
    assign out_tag   = out_tag_q;
    assign div_zero  = div_zero_q;

endmodule
